// File: rtl/conv_stream_kxk.sv
// conv_stream_kxk
// Streaming KxK convolution engine. A job begins with start. The K*K weights
// are then loaded serially. After that the IMG_H x IMG_W feature map streams in
// raster order, one pixel per accepted cycle. One output pixel is produced for
// every complete KxK window. There is no padding and the stride is 1. Each
// result is right-shifted by SHIFT and saturated to DW bits, unsigned.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        begins a job (only seen while idle)
//   filter_valid in_filter carries a weight this cycle (only seen while loading)
//   in_filter    weight word
//   ifmap_valid  in_ifmap carries a pixel this cycle
//   in_ifmap     pixel word, raster order
//   ifmap_ready  high while streaming; a pixel is taken on valid & ready
//   out_valid    one-cycle pulse per result
//   out          saturated result, held between results
//   out_last     marks the final result of the job
//   busy         high whenever a job is in progress
//   done         one-cycle pulse at job end
module conv_stream_kxk #(
  parameter int DW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int ACC_W = 20,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          filter_valid,
  input  logic [DW-1:0] in_filter,
  input  logic          ifmap_valid,
  input  logic [DW-1:0] in_ifmap,
  output logic          ifmap_ready,
  output logic          out_valid,
  output logic [DW-1:0] out,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int NW = K * K;
  localparam int IW = $clog2(NW + 1);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, LOAD_FILT, STREAM, FINISH} state_e;

  state_e        state_q;
  logic [IW-1:0] wIdx_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          ifmapReady_q;
  logic          busy_q;
  logic          done_q;
  logic          winValid_q;
  logic          winLast_q;
  logic          outValid_q;
  logic          outLast_q;
  logic [DW-1:0] out_q;

  logic [DW-1:0] weight_q  [NW];
  logic [DW-1:0] lineBuf_q [K-1][IMG_W];
  logic [DW-1:0] win_q     [K][K];

  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] shifted_d;
  logic [DW-1:0]    sat_d;

  logic pixAccept;
  logic lastPix;
  logic winComplete;
  logic weightWe;
  logic lastWeight;

  assign pixAccept   = ifmap_valid & ifmapReady_q;
  assign lastPix     = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  // Only windows that lie fully inside one block of K rows are valid.
  // Positions that straddle a row boundary fail the column test.
  assign winComplete = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign weightWe    = (state_q == LOAD_FILT) & filter_valid;
  assign lastWeight  = (wIdx_q == IW'(NW - 1));

  // Control FSM. It sequences weight loading, pixel counting and the
  // end-of-job handshake. winValid/winLast mark the edge at which the window
  // array holds a complete window, so the MAC result is registered one edge
  // later. done is raised one edge after out_last and is then held for a
  // single cycle. busy drops together with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wIdx_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ifmapReady_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      winValid_q   <= 1'b0;
      winLast_q    <= 1'b0;
    end else begin
      winValid_q <= pixAccept & winComplete;
      winLast_q  <= pixAccept & lastPix;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_FILT;
            busy_q  <= 1'b1;
            wIdx_q  <= '0;
          end
        end
        LOAD_FILT: begin
          if (filter_valid) begin
            if (lastWeight) begin
              state_q      <= STREAM;
              ifmapReady_q <= 1'b1;
              wIdx_q       <= '0;
              row_q        <= '0;
              col_q        <= '0;
            end else begin
              wIdx_q <= wIdx_q + IW'(1);
            end
          end
        end
        STREAM: begin
          if (pixAccept) begin
            if (col_q == CW'(IMG_W - 1)) begin
              col_q <= '0;
              row_q <= lastPix ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (lastPix) begin
              ifmapReady_q <= 1'b0;
              state_q      <= FINISH;
            end
          end
        end
        FINISH: begin
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (outLast_q) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Multiply-accumulate over the current window, then scale and saturate.
  // The accumulator width is chosen wide enough that no overflow can occur.
  always_comb begin
    acc_d = '0;
    for (int rr = 0; rr < K; rr++) begin
      for (int cc = 0; cc < K; cc++) begin
        acc_d = acc_d + ACC_W'(weight_q[rr*K+cc]) * ACC_W'(win_q[rr][cc]);
      end
    end
    shifted_d = acc_d >> SHIFT;
    sat_d     = (|shifted_d[ACC_W-1:DW]) ? {DW{1'b1}} : shifted_d[DW-1:0];
  end

  // Datapath storage. Each line buffer delays the stream by exactly one image
  // row, so its tail gives the pixel directly above in the previous row. The
  // window shifts left, which keeps column 0 as the oldest pixel. This matches
  // the weight ordering (idx 0 = top-left). Nothing moves unless a pixel is
  // accepted, so gaps in ifmap_valid have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      out_q      <= '0;
      for (int i = 0; i < NW; i++) weight_q[i] <= '0;
      for (int j = 0; j < K-1; j++) begin
        for (int e = 0; e < IMG_W; e++) lineBuf_q[j][e] <= '0;
      end
      for (int rr = 0; rr < K; rr++) begin
        for (int cc = 0; cc < K; cc++) win_q[rr][cc] <= '0;
      end
    end else begin
      outValid_q <= winValid_q;
      outLast_q  <= winValid_q & winLast_q;
      if (winValid_q) out_q <= sat_d;
      if (weightWe) weight_q[wIdx_q] <= in_filter;
      if (pixAccept) begin
        lineBuf_q[0][0] <= in_ifmap;
        for (int j = 1; j < K-1; j++) lineBuf_q[j][0] <= lineBuf_q[j-1][IMG_W-1];
        for (int j = 0; j < K-1; j++) begin
          for (int e = 1; e < IMG_W; e++) lineBuf_q[j][e] <= lineBuf_q[j][e-1];
        end
        for (int rr = 0; rr < K; rr++) begin
          for (int cc = 0; cc < K-1; cc++) win_q[rr][cc] <= win_q[rr][cc+1];
        end
        win_q[K-1][K-1] <= in_ifmap;
        for (int rr = 0; rr < K-1; rr++) win_q[rr][K-1] <= lineBuf_q[K-2-rr][IMG_W-1];
      end
    end
  end

  assign ifmap_ready = ifmapReady_q;
  assign out_valid   = outValid_q;
  assign out         = out_q;
  assign out_last    = outLast_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_conv_stream_kxk.sv
// Testbench for conv_stream_kxk. It uses two instances that share every input:
// one with SHIFT=0 and one with SHIFT=12. Every expected result comes from a
// plain-arithmetic convolution of the image array held in the bench. Each
// result is expected exactly two cycles after its completing pixel is driven.
module tb_conv_stream_kxk;

  localparam int Dw   = 8;
  localparam int Kk   = 3;
  localparam int ImgW = 5;
  localparam int ImgH = 5;
  localparam int NPix = ImgW * ImgH;
  localparam int NW   = Kk * Kk;
  localparam int NRes = (ImgH - Kk + 1) * (ImgW - Kk + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          filterValid = 1'b0;
  logic [Dw-1:0] inFilter = '0;
  logic          ifmapValid = 1'b0;
  logic [Dw-1:0] inIfmap = '0;

  logic          ifmapReady, outValid, outLast, busy, done;
  logic [Dw-1:0] outData;
  logic          readyS, validS, lastS, busyS, doneS;
  logic [Dw-1:0] dataS;

  conv_stream_kxk #(.DW(Dw), .K(Kk), .IMG_W(ImgW), .IMG_H(ImgH), .ACC_W(20), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_valid(filterValid), .in_filter(inFilter),
    .ifmap_valid(ifmapValid), .in_ifmap(inIfmap), .ifmap_ready(ifmapReady),
    .out_valid(outValid), .out(outData), .out_last(outLast), .busy(busy), .done(done));

  conv_stream_kxk #(.DW(Dw), .K(Kk), .IMG_W(ImgW), .IMG_H(ImgH), .ACC_W(20), .SHIFT(12)) dutS (
    .clk(clk), .rst(rst), .start(start), .filter_valid(filterValid), .in_filter(inFilter),
    .ifmap_valid(ifmapValid), .in_ifmap(inIfmap), .ifmap_ready(readyS),
    .out_valid(validS), .out(dataS), .out_last(lastS), .busy(busyS), .done(doneS));

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
    int valS;
    bit last;
  } expT;

  typedef struct {
    int wKind;
    int pKind;
    bit toggle;
    bit noise;
    int expFirst;
    int expLast;
    int expFirstS;
    int expLastS;
  } vecT;

  expT expQ[$];
  vecT vecs[5];
  int  curW[NW];
  int  curImg[NPix];
  int  compared = 0;
  int  mismatched = 0;
  int  cycleCnt = 0;
  int  doneDue = -10;
  int  jobResults = 0;
  int  jobFirst = 0, jobLast = 0, jobFirstS = 0, jobLastS = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cycleCnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct definition of the convolution: a weighted sum over the window that
  // ends at (r,c), then the shift, then the clamp to 255.
  function automatic int refConv(input int r, input int c, input int sh);
    longint acc = 0;
    for (int i = 0; i < Kk; i++)
      for (int j = 0; j < Kk; j++)
        acc += longint'(curW[i*Kk+j]) * longint'(curImg[(r-Kk+1+i)*ImgW + (c-Kk+1+j)]);
    acc = acc >> sh;
    if (acc > 255) acc = 255;
    return int'(acc);
  endfunction

  // Output monitor: compares each result on its due cycle and flags any
  // out_valid or done that appears when none is expected.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      if (outValid) begin
        if (jobResults == 0) begin
          jobFirst  = int'(outData);
          jobFirstS = int'(dataS);
        end
        jobLast  = int'(outData);
        jobLastS = int'(dataS);
        jobResults++;
      end
      if (expQ.size() > 0 && expQ[0].due == cycleCnt) begin
        e = expQ.pop_front();
        checkOutput("out_valid", int'(outValid), 1);
        checkOutput("out", int'(outData), e.val);
        checkOutput("out_last", int'(outLast), int'(e.last));
        checkOutput("out_valid_shift12", int'(validS), 1);
        checkOutput("out_shift12", int'(dataS), e.valS);
      end else if (outValid) begin
        checkOutput("unexpected_out_valid", int'(outValid), 0);
      end
      if (cycleCnt == doneDue) begin
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("done_pulse_shift12", int'(doneS), 1);
        checkOutput("busy_during_done", int'(busy), 1);
      end else if (done) begin
        checkOutput("unexpected_done", int'(done), 0);
      end
      if (cycleCnt == doneDue + 1) begin
        checkOutput("busy_after_done", int'(busy), 0);
        checkOutput("done_one_cycle", int'(done), 0);
      end
    end
  end

  task automatic setWeights(input int kind);
    for (int i = 0; i < NW; i++) begin
      case (kind)
        0: curW[i] = 1;
        1: curW[i] = i + 1;
        2: curW[i] = 255;
        default: curW[i] = $urandom_range(0, (kind == 3) ? 3 : 255);
      endcase
    end
  endtask

  task automatic setPixels(input int kind);
    for (int i = 0; i < NPix; i++) begin
      case (kind)
        0: curImg[i] = i + 1;
        1: curImg[i] = 1;
        2: curImg[i] = 255;
        default: curImg[i] = $urandom_range(0, 255);
      endcase
    end
  endtask

  // Runs one job from start through stopAfter accepted pixels. Entered and
  // left at #1 after a rising edge. The start cycle also presents a junk
  // weight, which must not be captured.
  task automatic applyStimulus(input bit toggle, input bit noise, input bit randGap, input int stopAfter);
    int  pixIdx = 0;
    int  tries = 0;
    bit  phase = 1'b1;
    bit  v;
    int  r, c;
    checkOutput("busy_before_start", int'(busy), 0);
    start = 1'b1;
    filterValid = 1'b1;
    inFilter = 8'hA5;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    for (int i = 0; i < NW;) begin
      if (randGap && $urandom_range(0, 3) == 0) begin
        filterValid = 1'b0;
        inFilter = Dw'($urandom);
      end else begin
        filterValid = 1'b1;
        inFilter = Dw'(curW[i]);
        if (i == NW - 1) checkOutput("ready_before_last_weight", int'(ifmapReady), 0);
        i++;
      end
      tick();
    end
    filterValid = 1'b0;
    checkOutput("ready_after_weights", int'(ifmapReady), 1);
    checkOutput("ready_after_weights_shift12", int'(readyS), 1);
    while (pixIdx < stopAfter && tries < 400) begin
      if (toggle) v = phase;
      else if (randGap) v = ($urandom_range(0, 2) != 0);
      else v = 1'b1;
      phase = ~phase;
      ifmapValid = v;
      inIfmap = v ? Dw'(curImg[pixIdx]) : Dw'($urandom);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        filterValid = 1'($urandom_range(0, 1));
        inFilter = Dw'($urandom);
      end
      if (v && ifmapReady) begin
        r = pixIdx / ImgW;
        c = pixIdx % ImgW;
        if (r >= Kk - 1 && c >= Kk - 1)
          expQ.push_back('{cycleCnt + 2, refConv(r, c, 0), refConv(r, c, 12), pixIdx == NPix - 1});
        if (pixIdx == NPix - 1) doneDue = cycleCnt + 3;
        pixIdx++;
      end
      tick();
      tries++;
    end
    ifmapValid = 1'b0;
    start = 1'b0;
    filterValid = 1'b0;
    if (tries >= 400) checkOutput("pixel_accept_timeout", pixIdx, stopAfter);
    if (stopAfter == NPix) checkOutput("ready_after_last_pixel", int'(ifmapReady), 0);
  endtask

  task automatic waitJobEnd();
    int g = 0;
    while (cycleCnt <= doneDue + 1 && g < 60) begin
      tick();
      g++;
    end
    if (g >= 60) checkOutput("job_end_timeout", g, 0);
    checkOutput("pending_results", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic runVector(input vecT v);
    setWeights(v.wKind);
    setPixels(v.pKind);
    jobResults = 0;
    applyStimulus(v.toggle, v.noise, 1'b0, NPix);
    waitJobEnd();
    checkOutput("result_count", jobResults, NRes);
    checkOutput("first_result", jobFirst, v.expFirst);
    checkOutput("last_result", jobLast, v.expLast);
    checkOutput("first_result_shift12", jobFirstS, v.expFirstS);
    checkOutput("last_result_shift12", jobLastS, v.expLastS);
  endtask

  initial begin
    vecs[0] = '{0, 0, 1'b0, 1'b0, 63, 171, 0, 0};
    vecs[1] = '{1, 1, 1'b0, 1'b0, 45, 45, 0, 0};
    vecs[2] = '{2, 2, 1'b0, 1'b0, 255, 255, 142, 142};
    vecs[3] = '{0, 0, 1'b1, 1'b0, 63, 171, 0, 0};
    vecs[4] = '{0, 0, 1'b0, 1'b1, 63, 171, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ifmap_ready", int'(ifmapReady), 0);
    checkOutput("reset_out_valid", int'(outValid), 0);
    checkOutput("reset_out", int'(outData), 0);
    checkOutput("reset_out_last", int'(outLast), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) runVector(vecs[i]);

    // Reset in the middle of a job: every output must clear at once and no
    // done may follow.
    setWeights(0);
    setPixels(0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
    rst = 1'b0;
    #1;
    checkOutput("midreset_ifmap_ready", int'(ifmapReady), 0);
    checkOutput("midreset_out_valid", int'(outValid), 0);
    checkOutput("midreset_out", int'(outData), 0);
    checkOutput("midreset_out_last", int'(outLast), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_busy_shift12", int'(busyS), 0);
    expQ.delete();
    tick();
    tick();
    rst = 1'b1;
    // Stray pixels and weights while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      ifmapValid = 1'b1;
      inIfmap = Dw'($urandom);
      filterValid = 1'b1;
      inFilter = Dw'($urandom);
      tick();
    end
    ifmapValid = 1'b0;
    filterValid = 1'b0;
    checkOutput("idle_after_reset_busy", int'(busy), 0);
    checkOutput("idle_after_reset_ready", int'(ifmapReady), 0);
    checkOutput("idle_after_reset_last_shift12", int'(lastS), 0);
    runVector(vecs[0]);

    // Random jobs: random weights (small or full range), random pixels and
    // random gaps in both the weight stream and the pixel stream.
    for (int j = 0; j < 6; j++) begin
      setWeights((j % 2 == 0) ? 3 : 4);
      setPixels(5);
      jobResults = 0;
      applyStimulus(1'b0, (j == 5), 1'b1, NPix);
      waitJobEnd();
      checkOutput("random_result_count", jobResults, NRes);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
